// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I main controller: Moore FSM that sequences the instruction steps and drives the datapath controls.
// Optional macro RISCV_MC_ILLEGAL_TRAP_EN adds a sticky TRAP state for unknown opcodes.
module riscv_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         imm_src,
  output logic               reg_write,
  output logic [STATE_W-1:0] state_o,
  output logic               illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXEC_R   = STATE_W'(6),
    ALUWB    = STATE_W'(7),
    EXEC_I   = STATE_W'(8),
    JAL      = STATE_W'(9),
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    BEQ      = STATE_W'(10),
    TRAP     = STATE_W'(11)
`else
    BEQ      = STATE_W'(10)
`endif
  } state_t;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;

  // Moore output table; TRAP and unused encodings fall to the all-zero default.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_update = 1'b1;
      end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXEC_R:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      ALUWB:    c.reg_write = 1'b1;
      EXEC_I:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      JAL: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1;
      end
      BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC_R;
          OP_I:         state_d = EXEC_I;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXEC_R:   state_d = ALUWB;
      EXEC_I:   state_d = ALUWB;
      JAL:      state_d = ALUWB;
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
      TRAP:     state_d = TRAP;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // Outputs are registered by decoding the next state, so they change together with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ctrl_q  <= decode_ctrl(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

`ifdef RISCV_MC_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (rst)                 illegal_q <= 1'b0;
    else if (state_d == TRAP) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
  logic state_live;
  assign state_live = (state_q <= BEQ);
`else
  assign illegal = 1'b0;
  logic state_live;
  assign state_live = (state_q <= BEQ);
`endif

  always_comb begin
    imm_src = 2'b00;
    if (state_live) begin
      case (op)
        OP_SW:   imm_src = 2'b01;
        OP_BEQ:  imm_src = 2'b10;
        OP_JAL:  imm_src = 2'b11;
        default: imm_src = 2'b00;
      endcase
    end
  end

  // Write strobes are masked combinationally so an in-flight instruction cannot write during reset.
  assign pc_write   = ~rst & (ctrl_q.pc_update | (ctrl_q.branch & zero));
  assign ir_write   = ~rst & ctrl_q.ir_write;
  assign mem_write  = ~rst & ctrl_q.mem_write;
  assign reg_write  = ~rst & ctrl_q.reg_write;
  assign adr_src    = ctrl_q.adr_src;
  assign result_src = ctrl_q.result_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign state_o    = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed, table-driven bench for riscv_multicycle_ctrl; each record holds one cycle's inputs and expected outputs.
module tb_riscv_multicycle_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0] state_o;

  riscv_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .reg_write(reg_write), .state_o(state_o), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic [3:0] st;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  // exp packing: {pc_write, adr_src, mem_write, ir_write, result_src, a, b, alu_op, imm_src, reg_write, illegal}
  function automatic vec_t v(input logic r, input logic [6:0] o, input logic z, input logic [3:0] st,
                             input logic pcw, input logic adr, input logic mw, input logic irw,
                             input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] aop, input logic [1:0] imm, input logic rw, input logic ill);
    vec_t t;
    t.rst = r; t.op = o; t.zero = z; t.st = st;
    t.exp = {pcw, adr, mw, irw, rs, a, b, aop, imm, rw, ill};
    return t;
  endfunction

  task automatic run_row(input int idx, input vec_t t);
    logic [15:0] got;
    rst = t.rst; op = t.op; zero = t.zero;
    @(negedge clk);
    got = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_op, imm_src, reg_write, illegal};
    total++;
    if (state_o !== t.st) begin
      bad++;
      $display("FAIL row%0d state got=%0d want=%0d", idx, state_o, t.st);
    end
    total++;
    if (got !== t.exp) begin
      bad++;
      $display("FAIL row%0d outputs got=%b want=%b", idx, got, t.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles: FETCH muxes visible, strobes masked.
    tbl.push_back(v(1, LW, 0, 0,  0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    tbl.push_back(v(1, LW, 0, 0,  0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    // lw
    tbl.push_back(v(0, LW, 0, 0,  1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    tbl.push_back(v(0, LW, 0, 1,  0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
    tbl.push_back(v(0, LW, 0, 2,  0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00, 0,0));
    tbl.push_back(v(0, LW, 0, 3,  0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
    tbl.push_back(v(0, LW, 0, 4,  0,0,0,0, 2'b01,2'b00,2'b00,2'b00,2'b00, 1,0));
    // sw
    tbl.push_back(v(0, SW, 0, 0,  1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b01, 0,0));
    tbl.push_back(v(0, SW, 0, 1,  0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b01, 0,0));
    tbl.push_back(v(0, SW, 0, 2,  0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b01, 0,0));
    tbl.push_back(v(0, SW, 0, 5,  0,1,1,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 0,0));
    // R-type
    tbl.push_back(v(0, RT, 0, 0,  1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    tbl.push_back(v(0, RT, 0, 1,  0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
    tbl.push_back(v(0, RT, 0, 6,  0,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00, 0,0));
    tbl.push_back(v(0, RT, 0, 7,  0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 1,0));
    // I-type
    tbl.push_back(v(0, IT, 0, 0,  1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    tbl.push_back(v(0, IT, 0, 1,  0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
    tbl.push_back(v(0, IT, 0, 8,  0,0,0,0, 2'b00,2'b10,2'b01,2'b10,2'b00, 0,0));
    tbl.push_back(v(0, IT, 0, 7,  0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 1,0));
    // jal
    tbl.push_back(v(0, JL, 0, 0,  1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b11, 0,0));
    tbl.push_back(v(0, JL, 0, 1,  0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b11, 0,0));
    tbl.push_back(v(0, JL, 0, 9,  1,0,0,0, 2'b00,2'b01,2'b10,2'b00,2'b11, 0,0));
    tbl.push_back(v(0, JL, 0, 7,  0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b11, 1,0));
    // beq taken, then not taken
    tbl.push_back(v(0, BQ, 1, 0,  1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b10, 0,0));
    tbl.push_back(v(0, BQ, 1, 1,  0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10, 0,0));
    tbl.push_back(v(0, BQ, 1, 10, 1,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b10, 0,0));
    tbl.push_back(v(0, BQ, 0, 0,  1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b10, 0,0));
    tbl.push_back(v(0, BQ, 0, 1,  0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b10, 0,0));
    tbl.push_back(v(0, BQ, 0, 10, 0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b10, 0,0));
    // unknown opcode
    tbl.push_back(v(0, BAD, 0, 0, 1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    tbl.push_back(v(0, BAD, 0, 1, 0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    tbl.push_back(v(0, BAD, 0, 11, 0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,1));
    tbl.push_back(v(0, BAD, 0, 11, 0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,1));
    tbl.push_back(v(0, LW,  0, 11, 0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,1));
    tbl.push_back(v(1, LW,  0, 11, 0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,1));
`endif
    tbl.push_back(v(0, LW, 0, 0,  1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));

    rst = 1'b1; op = LW; zero = 1'b0;
    @(posedge clk);
    #1;
    foreach (tbl[i]) run_row(i, tbl[i]);

    // lw aborted by a one-cycle reset in MEMREAD
    run_row(100, v(0, LW, 0, 1,  0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
    run_row(101, v(0, LW, 0, 2,  0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00, 0,0));
    run_row(102, v(1, LW, 0, 3,  0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
    run_row(103, v(0, LW, 0, 0,  1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));
    // sw aborted in MEMWRITE: mem_write must stay low on the reset edge
    run_row(104, v(0, SW, 0, 1,  0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b01, 0,0));
    run_row(105, v(0, SW, 0, 2,  0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b01, 0,0));
    run_row(106, v(1, SW, 0, 5,  0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 0,0));
    run_row(107, v(0, SW, 0, 0,  1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b01, 0,0));
    // lw aborted in MEMWB: reg_write masked
    run_row(108, v(0, LW, 0, 1,  0,0,0,0, 2'b00,2'b01,2'b01,2'b00,2'b00, 0,0));
    run_row(109, v(0, LW, 0, 2,  0,0,0,0, 2'b00,2'b10,2'b01,2'b00,2'b00, 0,0));
    run_row(110, v(0, LW, 0, 3,  0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0));
    run_row(111, v(1, LW, 0, 4,  0,0,0,0, 2'b01,2'b00,2'b00,2'b00,2'b00, 0,0));
    run_row(112, v(0, LW, 0, 0,  1,0,0,1, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Moore-style main controller for the multicycle RV32I datapath.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK states from the instruction opcode.
- Drives the datapath mux selects, the write enables, and the 2-bit alu_op that feeds the ALU control decoder.
- Sits between the instruction register and the shared memory/ALU datapath; it is the producer side of the alu_op/op5 interface.

Parameters:
- STATE_W, 4, width of the state register. Must hold 11 states, or 12 with the optional trap state.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- op  in  7  instr[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- pc_write  out  1  PC register enable; equals pc_update | (branch & zero).
- adr_src  out  1  memory address: 0 = PC, 1 = result bus.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register and OldPC enable.
- result_src  out  2  result bus: 00 = ALUOut, 01 = read data, 10 = ALU result.
- alu_src_a  out  2  ALU A input: 00 = PC, 01 = OldPC, 10 = rs1 data.
- alu_src_b  out  2  ALU B input: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode from funct3/funct7.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- reg_write  out  1  register file write enable.
- state_o  out  STATE_W  current state, for debug and verification.
- illegal  out  1  sticky illegal-opcode flag; tied 0 unless the macro is defined.

Behaviour:
- One state register, updated on the rising edge of clk.
- rst high at an edge: state <= FETCH (0), illegal <= 0.
- While rst is high, the strobes pc_write, ir_write, mem_write and reg_write are forced to 0. This holds regardless of state.
- All mux outputs are decoded from state only (Moore). Any signal not listed for a state is 0.
- imm_src is decoded combinationally from op:
  - 0000011 / 0010011 -> 00.
  - 0100011 -> 01.
  - 1100011 -> 10.
  - 1101111 -> 11.
  - any other op -> 00.
- States, with outputs -> next state:
  - FETCH (0): adr_src=0, ir_write=1, a=00, b=10, alu_op=00, result_src=10, pc_update=1 -> DECODE.
  - DECODE (1): a=01, b=01, alu_op=00 (branch target into ALUOut). Next state by op:
    - lw (0000011) or sw (0100011) -> MEMADR.
    - R-type (0110011) -> EXEC_R.
    - I-type ALU (0010011) -> EXEC_I.
    - jal (1101111) -> JAL.
    - beq (1100011) -> BEQ.
    - any other op -> FETCH.
  - MEMADR (2): a=10, b=01, alu_op=00 -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD (3): adr_src=1, result_src=00 -> MEMWB.
  - MEMWB (4): result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE (5): adr_src=1, result_src=00, mem_write=1 -> FETCH.
  - EXEC_R (6): a=10, b=00, alu_op=10 -> ALUWB.
  - ALUWB (7): result_src=00, reg_write=1 -> FETCH.
  - EXEC_I (8): a=10, b=01, alu_op=10 -> ALUWB.
  - JAL (9): a=01, b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB.
  - BEQ (10): a=10, b=00, alu_op=01, result_src=00, branch=1 -> FETCH. pc_write = zero in this state.
- Any unused state encoding -> FETCH on the next edge, with all outputs 0.
- Instruction latency in cycles:
  - lw 5.
  - sw 4.
  - R-type 4.
  - I-type 4.
  - jal 4.
  - beq 3.
  - unknown opcode 2.
- op is sampled only in DECODE and MEMADR. It is assumed stable because ir_write is 0 outside FETCH.
- rst asserted mid-instruction aborts the instruction; no write strobe pulses on that edge.

Optional Feature:
- Macro: RISCV_MC_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown op in DECODE -> TRAP (11).
  - TRAP holds all outputs 0 except illegal=1 and stays in TRAP until rst.
  - illegal is set on entry to TRAP.
- Undefined: an unknown op returns to FETCH, illegal is constant 0, and TRAP is not synthesized.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> state_o=0 and all strobes 0 during reset. First cycle after release: ir_write=1, pc_write=1, alu_src_b=10.
- lw (op=0000011): state_o sequence 0,1,2,3,4,0. reg_write=1 only in state 4 with result_src=01; adr_src=1 in state 3.
- sw (op=0100011): sequence 0,1,2,5,0. mem_write=1 only in state 5; imm_src=01 throughout.
- R-type (op=0110011) then I-type (op=0010011): sequences 0,1,6,7,0 and 0,1,8,7,0. alu_op=10 in states 6 and 8.
- beq (op=1100011): zero=1 -> pc_write=1 in state 10; zero=0 -> pc_write=0. alu_op=01 in both cases, and the next state is 0.
- op=1111111 with the macro defined: state 1 -> 11 and illegal=1 held. Without the macro: state 1 -> 0. A 1-cycle rst pulse in state 3 forces state_o=0 on the next cycle.
